v_mem_arb: RTL and testbench
============================

Name: v_mem_arb

Overview:
- Two-requester arbiter in front of the single VRAM port that the vector memory stage drives.
- Requester 0 is the vector load/store path; requester 1 is the secondary master (host/DMA preload of vector data).
- Grants one VRAM beat per cycle (read or write) using round-robin with a bounded burst lock.
- Returns read data to the owning requester with fixed 1-cycle latency.

Parameters:
- ADDR_W, 64, VRAM address width (matches `VRAM_ADDR_BUS`).
- DATA_W, 512, VRAM data/mask width (= `VLEN`).
- MAX_BURST, 4, max consecutive grants to one requester while the other is requesting (>=1).

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_i[r]  in  1  request valid, for r = 0, 1 (each requester has its own port set below).
- we_i[r]  in  1  1 = write, 0 = read.
- addr_i[r]  in  ADDR_W  beat address.
- wdata_i[r]  in  DATA_W  write data.
- wmask_i[r]  in  DATA_W  per-bit write mask.
- gnt_o[r]  out  1  combinational grant; the beat is consumed when req_i[r] && gnt_o[r].
- rvalid_o[r]  out  1  read data valid for requester r.
- rdata_o  out  DATA_W  shared read data, qualified by rvalid_o.
- vram_ren_o  out  1  VRAM read enable.
- vram_wen_o  out  1  VRAM write enable.
- vram_addr_o  out  ADDR_W  VRAM address.
- vram_mask_o  out  DATA_W  VRAM write mask.
- vram_din_o  out  DATA_W  VRAM write data.
- vram_dout_i  in  DATA_W  VRAM read data, valid the cycle after vram_ren_o.

Behaviour:
- Reset (async, rst_n=0):
  - last_gnt=1, so requester 0 wins first.
  - burst_cnt=0, owner_q=0, rvalid_q=0.
  - All outputs 0: gnt_o, rvalid_o, vram_ren_o, vram_wen_o, address, data and mask.
- Arbitration (combinational, each cycle):
  - Only one requester asserting: it is granted.
  - Both asserting, default: the requester != last_gnt is granted (round-robin).
  - Burst-lock exception to the default: if last_gnt requested and was granted in the previous cycle, and burst_cnt < MAX_BURST, last_gnt keeps the grant.
  - Neither asserting: no grant, VRAM enables low.
- Burst counter:
  - On a grant to the same requester as last_gnt: burst_cnt increments, saturating at MAX_BURST.
  - On a grant to the other requester: burst_cnt=1 and last_gnt is updated.
  - On an idle cycle: burst_cnt=0 and last_gnt holds.
- VRAM drive: for the granted requester g,
  - vram_ren_o = !we_i[g]; vram_wen_o = we_i[g].
  - vram_addr_o, vram_din_o and vram_mask_o are taken from requester g.
  - With no grant, both enables are 0 and the data buses are 0.
- Read return:
  - On a granted read in cycle N: owner_q<=g and rvalid_q<=1.
  - In cycle N+1: rvalid_o[owner_q]=1 and rdata_o=vram_dout_i.
  - A non-read cycle clears rvalid_q next cycle.
  - Back-to-back reads (any mix of owners) are fully pipelined at 1 beat/cycle.
- Writes: complete in the grant cycle; no response.
- Simultaneous events:
  - A read grant in cycle N+1 and the return for cycle N coexist (different registers).
  - Read and write are never issued together, because there is a single grant.
- Handshake rules:
  - Requester holds req/we/addr/data stable until granted.
  - gnt_o depends on the req_i inputs but not on we/addr.
  - Deasserting req before grant is legal (request is dropped).
- Reset mid-operation: an in-flight read return is lost (rvalid_o forced 0). Requesters must reissue.
- MAX_BURST=1 degenerates to strict alternation under contention.

Decomposition:
- Shared package/header (alongside the existing `VRAM_*` / `VMEM_*` defines):
  - requester-index constants: VREQ_LSU=0, VREQ_AUX=1;
  - the MAX_BURST default macro.
- One natural sub-module: v_rr_arb2, the 2-way round-robin picker with burst counter. Inputs are req[1:0]; outputs are gnt[1:0], with last_gnt and burst_cnt as its state.
- The datapath mux and read-return tracking stay in v_mem_arb.

Test Plan:
- Reset, then both requesters idle: all outputs 0. Apply the single read req0 addr=0x8100_0000 -> vram_ren_o=1 with that address in the same cycle; next cycle rvalid_o[0]=1 and rdata_o equals vram_dout_i.
- Single write req1 addr=0x8100_0040, wdata=pattern A, mask all-ones -> vram_wen_o=1 with wdata=A and the mask in the grant cycle; rvalid_o stays 0.
- Both requesters continuously reading, MAX_BURST=4 -> grant sequence 0,0,0,0,1,1,1,1,0,...; each rvalid_o[r] appears exactly 1 cycle after its grant, with the correct owner.
- Alternating reads, req0 cycle N and req1 cycle N+1 -> rvalid_o[0] at N+1 and rvalid_o[1] at N+2, each carrying the matching vram_dout_i; no bubbles.
- Read granted, then rst_n pulsed low mid-cycle -> rvalid_o and enables drop to 0 immediately (async). After release, requester 0 wins first under contention.
- req1 asserts then deasserts while req0 holds a burst -> no grant ever issued to requester 1; burst_cnt saturates and requester 0 keeps being granted.

Source files
------------

// File: rtl/v_mem_arb_pkg.sv
// Shared constants for the vector-memory VRAM arbiter.
// No logic; requester indices and default widths only.
// No flow control here.
package v_mem_arb_pkg;

    localparam int VREQ_LSU      = 0;
    localparam int VREQ_AUX      = 1;
    localparam int MAX_BURST_DEF = 4;
    localparam int VRAM_ADDR_W   = 64;
    localparam int VLEN          = 512;

    function automatic logic [1:0] onehot2(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/v_rr_arb2.sv
// Two-way round-robin picker with a bounded burst lock.
// Latency: combinational grant, state updates on the grant edge.
// Backpressure: a losing requester simply sees no grant and waits.
module v_rr_arb2
    import v_mem_arb_pkg::*;
#(
    parameter int MAX_BURST = MAX_BURST_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    localparam int              CNT_W   = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);

    logic             last_gnt;
    logic [CNT_W-1:0] burst_cnt;
    logic             pick;
    logic             hold;

    // burst_cnt != 0 means last_gnt was also granted in the previous cycle.
    always_comb begin
        hold = (burst_cnt != '0) && (burst_cnt < CNT_MAX);
        pick = 1'b0;
        case (req)
            2'b01:   pick = 1'b0;
            2'b10:   pick = 1'b1;
            2'b11:   pick = hold ? last_gnt : ~last_gnt;
            default: pick = 1'b0;
        endcase
        gnt = (req != 2'b00) ? onehot2(pick) : 2'b00;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt  <= 1'b1;
            burst_cnt <= '0;
        end else if (req == 2'b00) begin
            burst_cnt <= '0;
        end else if (pick == last_gnt) begin
            if (burst_cnt != CNT_MAX)
                burst_cnt <= burst_cnt + CNT_W'(1);
        end else begin
            last_gnt  <= pick;
            burst_cnt <= CNT_W'(1);
        end
    end

endmodule

// File: rtl/v_mem_arb.sv
// Arbitrates the LSU and aux/DMA requesters onto the single VRAM port.
// Latency: grant and VRAM command same cycle, read data returned 1 cycle later.
// Backpressure: req is held until gnt; no stall on the read return path.
module v_mem_arb
    import v_mem_arb_pkg::*;
#(
    parameter int ADDR_W    = VRAM_ADDR_W,
    parameter int DATA_W    = VLEN,
    parameter int MAX_BURST = MAX_BURST_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [1:0]             req_i,
    input  logic [1:0]             we_i,
    input  logic [1:0][ADDR_W-1:0] addr_i,
    input  logic [1:0][DATA_W-1:0] wdata_i,
    input  logic [1:0][DATA_W-1:0] wmask_i,
    output logic [1:0]             gnt_o,
    output logic [1:0]             rvalid_o,
    output logic [DATA_W-1:0]      rdata_o,
    output logic                   vram_ren_o,
    output logic                   vram_wen_o,
    output logic [ADDR_W-1:0]      vram_addr_o,
    output logic [DATA_W-1:0]      vram_mask_o,
    output logic [DATA_W-1:0]      vram_din_o,
    input  logic [DATA_W-1:0]      vram_dout_i
);

    logic [1:0] gnt;
    logic       any_gnt;
    logic       g;
    logic       rd_issue;
    logic       rvalid_q;
    logic       owner_q;

    v_rr_arb2 #(.MAX_BURST(MAX_BURST)) u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req_i),
        .gnt   (gnt)
    );

    assign any_gnt  = |gnt;
    assign g        = gnt[VREQ_AUX];
    assign rd_issue = any_gnt && !we_i[g];

    // Outputs are forced low while reset is asserted, even with requests pending.
    always_comb begin
        gnt_o       = '0;
        vram_ren_o  = 1'b0;
        vram_wen_o  = 1'b0;
        vram_addr_o = '0;
        vram_din_o  = '0;
        vram_mask_o = '0;
        if (rst_n && any_gnt) begin
            gnt_o       = gnt;
            vram_ren_o  = !we_i[g];
            vram_wen_o  = we_i[g];
            vram_addr_o = addr_i[g];
            vram_din_o  = wdata_i[g];
            vram_mask_o = wmask_i[g];
        end
        rvalid_o = rvalid_q ? onehot2(owner_q) : 2'b00;
        rdata_o  = rvalid_q ? vram_dout_i : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid_q <= 1'b0;
            owner_q  <= 1'b0;
        end else begin
            rvalid_q <= rd_issue;
            if (rd_issue)
                owner_q <= g;
        end
    end

endmodule

// File: tb/tb_v_mem_arb.sv
// Scoreboard bench for v_mem_arb: the driver predicts each cycle's VRAM command and read return,
// a negedge monitor pops and compares against the DUT.
module tb_v_mem_arb;

    localparam int AW = 64;
    localparam int DW = 512;
    localparam int MAX_BURST = 4;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [1:0]          req_i, we_i;
    logic [1:0][AW-1:0]  addr_i;
    logic [1:0][DW-1:0]  wdata_i, wmask_i;
    logic [1:0]          gnt_o, rvalid_o;
    logic [DW-1:0]       rdata_o;
    logic                vram_ren_o, vram_wen_o;
    logic [AW-1:0]       vram_addr_o;
    logic [DW-1:0]       vram_mask_o, vram_din_o, vram_dout_i;

    always #5 clk = ~clk;

    v_mem_arb #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MAX_BURST)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_i       (req_i),
        .we_i        (we_i),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .wmask_i     (wmask_i),
        .gnt_o       (gnt_o),
        .rvalid_o    (rvalid_o),
        .rdata_o     (rdata_o),
        .vram_ren_o  (vram_ren_o),
        .vram_wen_o  (vram_wen_o),
        .vram_addr_o (vram_addr_o),
        .vram_mask_o (vram_mask_o),
        .vram_din_o  (vram_din_o),
        .vram_dout_i (vram_dout_i)
    );

    typedef struct {
        logic [1:0]    gnt;
        logic          ren;
        logic          wen;
        logic [AW-1:0] addr;
        logic [DW-1:0] din;
        logic [DW-1:0] mask;
    } vexp_t;

    typedef struct {
        int            due;
        logic [1:0]    rv;
        logic [DW-1:0] data;
    } rexp_t;

    vexp_t q_vram[$];
    rexp_t q_ret[$];
    int    hist[$];
    int    owner_m;
    int    cyc;
    int    errors;
    int    checks;
    bit    mon_en;
    bit    rd_prev;
    logic [AW-1:0] rd_addr_prev;

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return {8{a ^ 64'hC3C3_5A5A_0F0F_9696}};
    endfunction

    // Reference arbitration: length of the trailing unbroken run of grants to the last winner.
    function automatic int model_pick(input logic [1:0] rq);
        int run;
        if (rq == 2'b00) return -1;
        if (rq == 2'b01) return 0;
        if (rq == 2'b10) return 1;
        run = 0;
        for (int i = hist.size() - 1; i >= 0 && run < MAX_BURST; i--) begin
            if (hist[i] != owner_m) break;
            run++;
        end
        if (run > 0 && run < MAX_BURST) return owner_m;
        return 1 - owner_m;
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @step %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        q_ret.delete();
        q_vram.delete();
        owner_m = 1;
        rd_prev = 1'b0;
    endtask

    task automatic step(input logic [1:0] rq, input logic [1:0] we,
                        input logic [1:0][AW-1:0] a,
                        input logic [1:0][DW-1:0] wd, input logic [1:0][DW-1:0] wm,
                        output int g);
        vexp_t e;
        rexp_t r;
        @(posedge clk);
        #1;
        cyc++;
        req_i   = rq;
        we_i    = we;
        addr_i  = a;
        wdata_i = wd;
        wmask_i = wm;
        vram_dout_i = rd_prev ? mem_word(rd_addr_prev) : {16{$urandom}};
        g = model_pick(rq);
        hist.push_back(g);
        e.gnt = 2'b00; e.ren = 1'b0; e.wen = 1'b0;
        e.addr = '0; e.din = '0; e.mask = '0;
        rd_prev = 1'b0;
        if (g >= 0) begin
            owner_m = g;
            e.gnt  = (g == 1) ? 2'b10 : 2'b01;
            e.ren  = !we[g];
            e.wen  = we[g];
            e.addr = a[g];
            e.din  = wd[g];
            e.mask = wm[g];
            if (!we[g]) begin
                rd_prev      = 1'b1;
                rd_addr_prev = a[g];
                r.due  = cyc + 1;
                r.rv   = e.gnt;
                r.data = mem_word(a[g]);
                q_ret.push_back(r);
            end
        end
        q_vram.push_back(e);
    endtask

    vexp_t         me;
    rexp_t         mr;
    logic [1:0]    exp_rv;
    logic [DW-1:0] exp_d;

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && mon_en) begin
                if (q_vram.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_underflow @step %0d: got no expected entry, required one", cyc);
                end else begin
                    me = q_vram.pop_front();
                    chk("gnt_o", {510'b0, gnt_o}, {510'b0, me.gnt});
                    chk("vram_ren", {511'b0, vram_ren_o}, {511'b0, me.ren});
                    chk("vram_wen", {511'b0, vram_wen_o}, {511'b0, me.wen});
                    chk("vram_addr", {448'b0, vram_addr_o}, {448'b0, me.addr});
                    chk("vram_din", vram_din_o, me.din);
                    chk("vram_mask", vram_mask_o, me.mask);
                end
                exp_rv = 2'b00;
                exp_d  = '0;
                if (q_ret.size() > 0 && q_ret[0].due == cyc) begin
                    mr = q_ret.pop_front();
                    exp_rv = mr.rv;
                    exp_d  = mr.data;
                end
                chk("rvalid_o", {510'b0, rvalid_o}, {510'b0, exp_rv});
                if (exp_rv != 2'b00)
                    chk("rdata_o", rdata_o, exp_d);
            end
        end
    end

    logic [1:0][AW-1:0] ta;
    logic [1:0][DW-1:0] twd, twm;
    logic [1:0]         pend, pwe;
    int                 g;

    initial begin
        errors = 0; checks = 0; cyc = 0; mon_en = 1'b0;
        model_reset();
        rst_n = 1'b0;
        req_i = '0; we_i = '0; addr_i = '0; wdata_i = '0; wmask_i = '0;
        vram_dout_i = {16{32'hDEAD_BEEF}};
        #3;
        chk("rst_gnt", {510'b0, gnt_o}, '0);
        chk("rst_rvalid", {510'b0, rvalid_o}, '0);
        chk("rst_rdata", rdata_o, '0);
        chk("rst_en", {510'b0, vram_ren_o, vram_wen_o}, '0);
        chk("rst_addr", {448'b0, vram_addr_o}, '0);
        chk("rst_din_mask", vram_din_o | vram_mask_o, '0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        mon_en = 1'b1;

        twd = '0; twm = '0; ta = '0;
        step(2'b00, 2'b00, ta, twd, twm, g);
        step(2'b00, 2'b00, ta, twd, twm, g);

        // single read then single write
        ta[0] = 64'h8100_0000;
        step(2'b01, 2'b00, ta, twd, twm, g);
        ta[1] = 64'h8100_0040;
        twd[1] = {16{32'hA5A5_5A5A}};
        twm[1] = {DW{1'b1}};
        step(2'b10, 2'b10, ta, twd, twm, g);
        twd = '0; twm = '0;
        step(2'b00, 2'b00, ta, twd, twm, g);

        // both reading under contention
        for (int i = 0; i < 12; i++) begin
            ta[0] = 64'h1000 + 64'(i * 64);
            ta[1] = 64'h2000 + 64'(i * 64);
            step(2'b11, 2'b00, ta, twd, twm, g);
        end
        step(2'b00, 2'b00, ta, twd, twm, g);

        // alternating single reads, no bubbles
        for (int i = 0; i < 4; i++) begin
            ta[i % 2] = 64'h3000 + 64'(i * 64);
            step((i % 2 == 0) ? 2'b01 : 2'b10, 2'b00, ta, twd, twm, g);
        end
        step(2'b00, 2'b00, ta, twd, twm, g);

        // req1 pulses once during a req0 burst, then real contention after saturation
        for (int i = 0; i < 9; i++) begin
            ta[0] = 64'h4000 + 64'(i * 64);
            ta[1] = 64'h5000;
            step((i == 2 || i == 8) ? 2'b11 : 2'b01, 2'b00, ta, twd, twm, g);
        end

        // async reset while a read return is in flight
        ta[0] = 64'h6000; ta[1] = 64'h7000;
        step(2'b11, 2'b00, ta, twd, twm, g);
        @(posedge clk);
        #2;
        chk("pre_rst_rvalid", {511'b0, (rvalid_o != 2'b00)}, {511'b0, 1'b1});
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rvalid", {510'b0, rvalid_o}, '0);
        chk("mid_rst_en", {510'b0, vram_ren_o, vram_wen_o}, '0);
        chk("mid_rst_gnt", {510'b0, gnt_o}, '0);
        req_i = '0; we_i = '0;
        model_reset();
        @(negedge clk);
        #1 rst_n = 1'b1;
        step(2'b11, 2'b00, ta, twd, twm, g);
        #1;
        chk("post_rst_first_gnt", {510'b0, gnt_o}, {510'b0, 2'b01});
        step(2'b11, 2'b00, ta, twd, twm, g);

        // randomized traffic honouring hold-until-granted
        pend = '0; pwe = '0;
        for (int i = 0; i < 400; i++) begin
            for (int r = 0; r < 2; r++) begin
                if (!pend[r] && $urandom_range(0, 9) < 6) begin
                    pend[r] = 1'b1;
                    pwe[r]  = ($urandom_range(0, 2) == 0);
                    ta[r]   = {$urandom, $urandom};
                    twd[r]  = {16{$urandom}};
                    twm[r]  = {16{$urandom}};
                end else if (pend[r] && $urandom_range(0, 19) == 0) begin
                    pend[r] = 1'b0;
                end
            end
            step(pend, pwe, ta, twd, twm, g);
            if (g >= 0) pend[g] = 1'b0;
        end

        twd = '0; twm = '0;
        step(2'b00, 2'b00, ta, twd, twm, g);
        step(2'b00, 2'b00, ta, twd, twm, g);
        @(negedge clk);
        #1;
        chk("ret_queue_drained", 512'(q_ret.size()), '0);
        chk("vram_queue_drained", 512'(q_vram.size()), '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
